// File: rtl/rf_probe_scan_if.sv
// Handshake and probe bus between the debug controller, rf_probe_scan and the register file probe port.
interface rf_probe_scan_if;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        busy;
    logic        done;
    logic [4:0]  ahb_rf_addr;
    logic [31:0] ahb_rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;

    modport slave (
        input  start, abort, first_addr, last_addr, ahb_rf_data, out_ready,
        output busy, done, ahb_rf_addr, out_valid, out_addr, out_data
    );

    modport master (
        output start, abort, first_addr, last_addr, ahb_rf_data, out_ready,
        input  busy, done, ahb_rf_addr, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/rf_probe_scan.sv
// Streams a contiguous (wrapping) range of the 32 integer registers from the probe port
// as (index, value) beats, hiding the port's one-cycle read latency behind a 2-entry FIFO.
module rf_probe_scan (
    input  logic          clk,
    input  logic          rstn,
    rf_probe_scan_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [4:0]        ptr_q, ptr_d;
    logic [5:0]        rem_q, rem_d;
    logic              infl_q, infl_d;
    logic [4:0]        infl_idx_q, infl_idx_d;
    logic              done_q, done_d;

    logic [1:0][4:0]   fifo_addr_q;
    logic [1:0][31:0]  fifo_data_q;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0]        cnt_q, cnt_d;

    logic [5:0]        len;
    logic [2:0]        occ;
    logic              out_valid;
    logic              push, pop, issue_en;

    assign len       = {1'b0, bus.last_addr - bus.first_addr} + 6'd1;
    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid & bus.out_ready;
    assign push      = infl_q;
    assign occ       = {1'b0, cnt_q} + {2'b00, infl_q};

    // A slot freed by this cycle's pop is reusable by the read issued now: it lands a cycle later.
    assign issue_en  = (state_q == S_SCAN) && !bus.abort &&
                       ((occ < 3'd2) || ((occ == 3'd2) && pop));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ptr_d   = bus.first_addr;
                    rem_d   = len;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (issue_en) begin
                    ptr_d = ptr_q + 5'd1;
                    rem_d = rem_q - 6'd1;
                    if (rem_q == 6'd1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!infl_q && (cnt_q == 2'd1) && pop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        infl_d     = issue_en;
        infl_idx_d = ptr_q;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        wr_d       = wr_q ^ push;
        rd_d       = rd_q ^ pop;
        if (bus.abort) begin
            infl_d = 1'b0;
            cnt_d  = 2'd0;
            wr_d   = 1'b0;
            rd_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            ptr_q       <= 5'd0;
            rem_q       <= 6'd0;
            infl_q      <= 1'b0;
            infl_idx_q  <= 5'd0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cnt_q       <= 2'd0;
            fifo_addr_q <= '0;
            fifo_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            infl_q     <= infl_d;
            infl_idx_q <= infl_idx_d;
            done_q     <= done_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            if (push) begin
                fifo_addr_q[wr_q] <= infl_idx_q;
                fifo_data_q[wr_q] <= bus.ahb_rf_data;
            end
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.ahb_rf_addr = ptr_q;
    assign bus.out_valid   = out_valid;
    // Stale entries stay hidden once the FIFO is emptied by abort or a final pop.
    assign bus.out_addr    = out_valid ? fifo_addr_q[rd_q] : 5'd0;
    assign bus.out_data    = out_valid ? fifo_data_q[rd_q] : 32'd0;
endmodule

// File: tb/tb_rf_probe_scan.sv
// Random-backpressure bench for rf_probe_scan against a queue-based model of the expected beat stream.
module tb_rf_probe_scan;
    logic clk = 1'b0;
    logic rstn;
    rf_probe_scan_if bus();

    rf_probe_scan dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    // Register file probe port: one-cycle registered read.
    logic [31:0] rf [32];
    always @(posedge clk) bus.ahb_rf_data <= rf[bus.ahb_rf_addr];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},  64'(bus.busy), 64'd0);
        chk({tag, "_done"},  64'(bus.done), 64'd0);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_oaddr"}, 64'(bus.out_addr), 64'd0);
        chk({tag, "_odata"}, 64'(bus.out_data), 64'd0);
        chk({tag, "_raddr"}, 64'(bus.ahb_rf_addr), 64'd0);
    endtask

    // mode 0: ready always high, 1: random per cycle, 2: random 16-cycle repeating pattern
    task automatic scan(input logic [4:0] f, input logic [4:0] l, input int mode,
                        input int abort_beat, input int restart_at);
        int          len, pops, first_v, done_c, last_pop;
        bit          busy_ok, seen;
        logic [15:0] pat;
        logic [4:0]  exq[$];
        logic [4:0]  a;
        len = ((int'(l) - int'(f) + 32) % 32) + 1;
        for (int i = 0; i < len; i++) begin
            a = 5'((int'(f) + i) % 32);
            exq.push_back(a);
        end
        pat = 16'($urandom) | 16'h0001;

        @(negedge clk);
        bus.start = 1'b1; bus.first_addr = f; bus.last_addr = l;
        @(negedge clk);
        bus.start = 1'b0;
        bus.first_addr = 5'($urandom);
        bus.last_addr  = 5'($urandom);
        chk("busy_rise", 64'(bus.busy), 64'd1);
        chk("first_probe_addr", 64'(bus.ahb_rf_addr), 64'(f));

        pops = 0; first_v = 0; done_c = 0; last_pop = 0; busy_ok = 1'b1;
        for (int c = 1; c < 400; c++) begin
            if (c > 1) @(negedge clk);
            bus.start = (c == restart_at);
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom);
                default: bus.out_ready = pat[c % 16];
            endcase
            if (bus.done) begin done_c = c; break; end
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.out_valid && first_v == 0) first_v = c;
            if (abort_beat != 0 && bus.out_valid && pops == abort_beat - 1) begin
                bus.abort = 1'b1; bus.out_ready = 1'b0; done_c = -1;
                break;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (pops < len) begin
                    chk("beat_addr", 64'(bus.out_addr), 64'(exq[pops]));
                    chk("beat_data", 64'(bus.out_data), 64'(rf[exq[pops]]));
                end else begin
                    chk("extra_beat", 64'(pops + 1), 64'(len));
                end
                pops++;
                last_pop = c;
            end
        end
        bus.start = 1'b0;

        if (done_c == -1) begin
            @(negedge clk);
            bus.abort = 1'b0;
            chk("abort_valid", 64'(bus.out_valid), 64'd0);
            chk("abort_busy", 64'(bus.busy), 64'd0);
            chk("abort_beats", 64'(pops), 64'(abort_beat - 1));
            seen = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (bus.done) seen = 1'b1;
            end
            chk("abort_no_done", 64'(seen), 64'd0);
        end else if (done_c == 0) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            chk("beat_count", 64'(pops), 64'(len));
            chk("done_after_pop", 64'(done_c), 64'(last_pop + 1));
            chk("busy_fall", 64'(bus.busy), 64'd0);
            chk("busy_held", 64'(busy_ok), 64'd1);
            if (mode == 0) begin
                chk("first_valid_cycle", 64'(first_v), 64'd3);
                chk("done_cycle", 64'(done_c), 64'(len + 3));
            end
            @(negedge clk);
            chk("done_pulse", 64'(bus.done), 64'd0);
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        bus.start = 1'b1; bus.first_addr = 5'd0; bus.last_addr = 5'd31;
        @(negedge clk);
        bus.start = 1'b0; bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk_idle_zero("mid_reset");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
        bus.first_addr = 5'd0; bus.last_addr = 5'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rstn = 1'b1;

        scan(5'd0, 5'd31, 0, 0, 0);
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        scan(5'd30, 5'd1, 0, 0, 0);
        scan(5'd7, 5'd7, 0, 0, 0);
        scan(5'd3, 5'd18, 2, 0, 0);
        scan(5'd25, 5'd9, 1, 0, 0);
        scan(5'd0, 5'd31, 2, 0, 0);
        scan(5'd10, 5'd20, 0, 5, 0);
        scan(5'd10, 5'd20, 0, 0, 0);
        scan(5'd4, 5'd12, 0, 0, 3);
        scan(5'd14, 5'd29, 1, 0, 6);

        // abort and start together in IDLE: abort wins
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.first_addr = 5'd2; bus.last_addr = 5'd9;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abort_beats_start", 64'(bus.busy), 64'd0);
        repeat (4) @(negedge clk);
        chk("abort_start_valid", 64'(bus.out_valid), 64'd0);

        reset_mid();
        scan(5'd28, 5'd2, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            scan(5'($urandom), 5'($urandom), 1 + (k % 2), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
